// File: rtl/lsu_mem_master.sv
// Load/store master for a word-only data memory: lane extract/extend on loads, RMW for SB/SH.
// Latency N+2 (load/SW), N+3 (SB/SH), N+1 (fault); no rsp back-pressure. Macro LSU_MISALIGN_TRAP_EN traps misalignment.
module lsu_mem_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  // Only the fields the later states need: lane bits and the sub-word store data.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  state_t      state;
  req_t        r;
  logic        illegal;
  logic [1:0]  acc_lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    illegal  = (req_size == 2'b11);
    acc_lane = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size == SZ_H && req_addr[0])          illegal = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00) illegal = 1'b1;
`else
    if (req_size == SZ_H) acc_lane[0] = 1'b0;
    if (req_size == SZ_W) acc_lane    = 2'b00;
`endif
  end

  always_comb begin
    byte_v    = mem_rd[{r.lane, 3'b000} +: 8];
    half_v    = r.lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_data = mem_rd;
    merged    = mem_rd;
    case (r.size)
      SZ_B: begin
        load_data = r.uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merged[{r.lane, 3'b000} +: 8] = r.wdata[7:0];
      end
      SZ_H: begin
        load_data = r.uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        merged[{r.lane[1], 4'b0000} +: 16] = r.wdata;
      end
      default: ;
    endcase
  end

  // Decoded from state so the async reset removes the write strobe immediately.
  assign mem_we    = (state == WRITE) || (state == ACCESS && r.we && r.size == SZ_W);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      mem_a     <= '0;
      mem_wd    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r         <= '{we: req_we, size: req_size, uns: req_unsigned,
                           lane: acc_lane, wdata: req_wdata[15:0]};
            rsp_rdata <= '0;
            rsp_fault <= illegal;
            if (illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= ACCESS;
              mem_a <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_we && req_size == SZ_W) mem_wd <= req_wdata;
            end
          end
        end
        ACCESS: begin
          if (!r.we) begin
            rsp_rdata <= load_data;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else if (r.size == SZ_W) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            mem_wd <= merged;
            state  <= WRITE;
          end
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a word-addressed memory model.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];

  int checks = 0;
  int passes = 0;

  lsu_mem_master #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  // Drives one request, then observes six cycles; lat=k means rsp_valid in cycle N+k.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic fault,
                         output int we_cnt, output int vld_cnt);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 0; rdata = '0; fault = 1'b0; we_cnt = 0; vld_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_we) we_cnt++;
      if (rsp_valid) begin
        vld_cnt++;
        if (lat == 0) begin lat = k; rdata = rsp_rdata; fault = rsp_fault; end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); else passes++;
    checks++; if (rsp_fault !== 1'b0) $display("FAIL reset_rsp_fault got %b want 0", rsp_fault); else passes++;
    checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else passes++;
    checks++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a got %h want 0", mem_a); else passes++;
    checks++; if (mem_wd !== 32'h0) $display("FAIL reset_mem_wd got %h want 0", mem_wd); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_load_word;
    int lat, wc, vc; logic [31:0] rd; logic f;
    mem[64] = 32'h8899AABB;
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, f, wc, vc);
    checks++; if (lat != 2) $display("FAIL lw_latency got %0d want 2", lat); else passes++;
    checks++; if (rd !== 32'h8899AABB) $display("FAIL lw_rdata got %h want 8899aabb", rd); else passes++;
    checks++; if (f !== 1'b0) $display("FAIL lw_fault got %b want 0", f); else passes++;
    checks++; if (wc != 0) $display("FAIL lw_mem_we got %0d cycles want 0", wc); else passes++;
    checks++; if (vc != 1) $display("FAIL lw_rsp_pulses got %0d want 1", vc); else passes++;
  endtask

  task automatic test_load_lanes;
    int lat, wc, vc; logic [31:0] rd; logic f;
    run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, f, wc, vc);
    checks++; if (rd !== 32'hFFFFFF88) $display("FAIL lb_103 got %h want ffffff88", rd); else passes++;
    checks++; if (lat != 2) $display("FAIL lb_latency got %0d want 2", lat); else passes++;
    run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, f, wc, vc);
    checks++; if (rd !== 32'h00000088) $display("FAIL lbu_103 got %h want 00000088", rd); else passes++;
    run_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, rd, f, wc, vc);
    checks++; if (rd !== 32'hFFFFFFAA) $display("FAIL lb_101 got %h want ffffffaa", rd); else passes++;
    run_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, f, wc, vc);
    checks++; if (rd !== 32'hFFFF8899) $display("FAIL lh_102 got %h want ffff8899", rd); else passes++;
    run_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, lat, rd, f, wc, vc);
    checks++; if (rd !== 32'h0000AABB) $display("FAIL lhu_100 got %h want 0000aabb", rd); else passes++;
    run_req(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, lat, rd, f, wc, vc);
    checks++; if (rd !== 32'h8899AABB) $display("FAIL lw_unsigned got %h want 8899aabb", rd); else passes++;
  endtask

  task automatic test_store_byte;
    int lat, wc, vc; logic [31:0] rd; logic f;
    run_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345677, lat, rd, f, wc, vc);
    checks++; if (mem[64] !== 32'h889977BB) $display("FAIL sb_mem got %h want 889977bb", mem[64]); else passes++;
    checks++; if (wc != 1) $display("FAIL sb_mem_we got %0d cycles want 1", wc); else passes++;
    checks++; if (lat != 3) $display("FAIL sb_latency got %0d want 3", lat); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL sb_rdata got %h want 0", rd); else passes++;
  endtask

  task automatic test_store_word;
    int lat, wc, vc; logic [31:0] rd; logic f;
    mem[65] = 32'h0;
    run_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, lat, rd, f, wc, vc);
    checks++; if (mem[65] !== 32'hDEADBEEF) $display("FAIL sw_mem got %h want deadbeef", mem[65]); else passes++;
    checks++; if (wc != 1) $display("FAIL sw_mem_we got %0d cycles want 1", wc); else passes++;
    checks++; if (lat != 2) $display("FAIL sw_latency got %0d want 2", lat); else passes++;
    checks++; if (mem[64] !== 32'h889977BB) $display("FAIL sw_neighbour got %h want 889977bb", mem[64]); else passes++;
  endtask

  task automatic test_misaligned;
    int lat, wc, vc; logic [31:0] rd; logic f;
    run_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000CAFE, lat, rd, f, wc, vc);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (f !== 1'b1) $display("FAIL sh_mis_fault got %b want 1", f); else passes++;
    checks++; if (lat != 1) $display("FAIL sh_mis_latency got %0d want 1", lat); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL sh_mis_rdata got %h want 0", rd); else passes++;
    checks++; if (wc != 0) $display("FAIL sh_mis_mem_we got %0d want 0", wc); else passes++;
    checks++; if (mem[64] !== 32'h889977BB) $display("FAIL sh_mis_mem got %h want 889977bb", mem[64]); else passes++;
    mem[64] = 32'h8899CAFE;
`else
    checks++; if (f !== 1'b0) $display("FAIL sh_mis_fault got %b want 0", f); else passes++;
    checks++; if (lat != 3) $display("FAIL sh_mis_latency got %0d want 3", lat); else passes++;
    checks++; if (wc != 1) $display("FAIL sh_mis_mem_we got %0d want 1", wc); else passes++;
    checks++; if (mem[64] !== 32'h8899CAFE) $display("FAIL sh_mis_mem got %h want 8899cafe", mem[64]); else passes++;
    run_req(1'b0, 2'b10, 1'b0, 32'h106, 32'h0, lat, rd, f, wc, vc);
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_mis_106 got %h want deadbeef", rd); else passes++;
`endif
  endtask

  task automatic test_illegal_size;
    int lat, wc, vc; logic [31:0] rd; logic f;
    run_req(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, lat, rd, f, wc, vc);
    checks++; if (f !== 1'b1) $display("FAIL size11_fault got %b want 1", f); else passes++;
    checks++; if (lat != 1) $display("FAIL size11_latency got %0d want 1", lat); else passes++;
    checks++; if (wc != 0) $display("FAIL size11_mem_we got %0d want 0", wc); else passes++;
    checks++; if (mem[64] !== 32'h8899CAFE) $display("FAIL size11_mem got %h want 8899cafe", mem[64]); else passes++;
  endtask

  task automatic test_reset_mid_write;
    int vc;
    vc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h00000011;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1) $display("FAIL rstmid_write_cycle got mem_we=%b want 1", mem_we); else passes++;
    rst = 1'b1; #1;
    checks++; if (mem_we !== 1'b0) $display("FAIL rstmid_mem_we_drop got %b want 0", mem_we); else passes++;
    repeat (2) begin @(negedge clk); if (rsp_valid) vc++; end
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) $display("FAIL rstmid_req_ready got %b want 1", req_ready); else passes++;
    repeat (4) begin @(negedge clk); if (rsp_valid) vc++; end
    checks++; if (vc != 0) $display("FAIL rstmid_rsp_valid got %0d pulses want 0", vc); else passes++;
    checks++; if (mem[64] !== 32'h8899CAFE) $display("FAIL rstmid_mem got %h want 8899cafe", mem[64]); else passes++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_n1 got %b want 0", req_ready); else passes++;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_n2 got %b want 0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8899CAFE)
      $display("FAIL b2b_first_rsp got vld=%b data=%h want vld=1 data=8899cafe", rsp_valid, rsp_rdata); else passes++;
    req_we = 1'b1; req_addr = 32'h104; req_wdata = 32'h0BADF00D;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL b2b_n3 got ready=%b vld=%b want ready=1 vld=0", req_ready, rsp_valid); else passes++;
    @(negedge clk); req_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'h104)
      $display("FAIL b2b_sw_access got we=%b a=%h want we=1 a=104", mem_we, mem_a); else passes++;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL b2b_second_rsp got vld=%b f=%b data=%h want 1 0 0", rsp_valid, rsp_fault, rsp_rdata); else passes++;
    checks++; if (mem[65] !== 32'h0BADF00D) $display("FAIL b2b_sw_mem got %h want 0badf00d", mem[65]); else passes++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_load_word();
    test_load_lanes();
    test_store_byte();
    test_store_word();
    test_misaligned();
    test_illegal_size();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed data memory port (we, a, wd, rd) on behalf of the core.
- Accepts byte/halfword/word load and store requests over a valid/ready handshake.
- Performs lane extraction and sign/zero extension for loads.
- Performs read-modify-write for sub-word stores, because the memory only writes full words.
- Sits between the core's execute stage and the data memory in the multi-cycle datapath variant.

Parameters:
- ADDR_WIDTH, 32, width of request and memory address buses.
- DATA_WIDTH is fixed at 32 and is not a parameter; the byte-lane logic depends on it.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  input  1  zero-extend loads (LBU/LHU)
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle pulse: request complete
- rsp_rdata  output  32  load result, extended; 0 for stores and faults
- rsp_fault  output  1  valid with rsp_valid: misaligned or illegal size
- mem_we  output  1  memory write enable
- mem_a  output  ADDR_WIDTH  memory byte address, always word-aligned (bits [1:0] = 0)
- mem_wd  output  32  memory write data
- mem_rd  input  32  memory read data, combinational from mem_a

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_we=0, mem_a=0, mem_wd=0, FSM in IDLE.
- mem_we is decoded from the state register, so it drops immediately when rst is asserted.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - If the request is illegal (size 11, half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with fault=1.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_a = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Load: register the extracted lane from mem_rd into rsp_rdata; go to RESP.
  - Store word: mem_we=1, mem_wd=wdata; go to RESP.
  - Store byte/half: capture mem_rd into a merge buffer; go to WRITE.
- WRITE:
  - mem_we=1.
  - mem_wd = merge buffer with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; go to IDLE. There is no response back-pressure.
- req_ready=0 in ACCESS, WRITE and RESP.
- Latency, with N = accept cycle: rsp_valid in cycle N+2 for loads and SW, N+3 for SB/SH, N+1 for faults.
- Maximum throughput is one request per 3 cycles (loads/SW).
- Lane selection:
  - Byte lane = addr[1:0]; byte k occupies bits [8k+7:8k].
  - Half lane = addr[1]; low half at 0, high half at 2.
- Extension: sign-extend from bit 7/15 unless req_unsigned; req_unsigned is ignored for words.
- mem_we is asserted for exactly one cycle per store and never for loads or faults.
- mem_a and mem_wd hold their values outside write cycles.
- Reset mid-operation:
  - FSM returns to IDLE and mem_we=0 asynchronously.
  - No write occurs unless the write edge preceded reset.
  - No rsp_valid is issued for the aborted request.
- A req_valid present in the same cycle as rst release is not accepted; acceptance starts on the first clock edge after release.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word requests fault as described above, with no memory access.
- Undefined:
  - Misaligned requests are not faulted; address low bits are force-aligned (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.
  - Size 11 is still faulted in both builds.

Test Plan:
1. Memory word 0x100 = 0x8899AABB; LW 0x100 -> rsp_rdata=0x8899AABB at N+2, rsp_fault=0, mem_we never 1.
2. LB 0x103 -> 0xFFFFFF88; LBU 0x103 -> 0x00000088; LH 0x102 -> 0xFFFF8899; LHU 0x100 -> 0x0000AABB.
3. SB 0x101, wdata 0x12345677 -> word 0x100 becomes 0x889977BB; mem_we high for exactly one cycle (WRITE); rsp_valid at N+3.
4. SH 0x101 with macro on -> rsp_fault=1 at N+1, rsp_rdata=0, memory unchanged. Macro off, wdata 0x0000CAFE -> word 0x100 becomes 0x8899CAFE.
5. Issue SB, then assert rst during WRITE -> mem_we falls the same cycle, memory unchanged, no rsp_valid, req_ready=1 after release.
6. req_valid held high with LW 0x100 then SW 0x104 -> req_ready=0 in cycles N+1..N+2; second request accepted at N+3; responses in order.
